// File: rtl/decode_writeback.sv
// Y86-64 decode/write-back stage: register file, source/destination selection,
// E/M/W forwarding and the E pipeline register. Optional macro: DEC_REG_DEBUG_EN.
module decode_writeback #(
   parameter logic [3:0] RSP_ID   = 4'h4,
   parameter logic [3:0] RNONE    = 4'hF,
   parameter logic [3:0] STAT_AOK = 4'h1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  D_icode,
   input  logic [3:0]  D_ifun,
   input  logic [3:0]  D_rA,
   input  logic [3:0]  D_rB,
   input  logic [3:0]  D_stat,
   input  logic [63:0] D_valC,
   input  logic [63:0] D_valP,
   input  logic [3:0]  e_dstE,
   input  logic [63:0] e_valE,
   input  logic [3:0]  M_dstE,
   input  logic [3:0]  M_dstM,
   input  logic [63:0] M_valE,
   input  logic [63:0] m_valM,
   input  logic [3:0]  W_icode,
   input  logic [3:0]  W_dstE,
   input  logic [3:0]  W_dstM,
   input  logic [63:0] W_valE,
   input  logic [63:0] W_valM,
   input  logic        E_bubble,
   output logic [3:0]  d_srcA,
   output logic [3:0]  d_srcB,
   output logic [3:0]  E_icode,
   output logic [3:0]  E_ifun,
   output logic [3:0]  E_stat,
   output logic [3:0]  E_dstE,
   output logic [3:0]  E_dstM,
   output logic [3:0]  E_srcA,
   output logic [3:0]  E_srcB,
   output logic [63:0] E_valC,
   output logic [63:0] E_valA,
   output logic [63:0] E_valB
`ifdef DEC_REG_DEBUG_EN
   ,
   input  logic [3:0]  dbg_sel,
   output logic [63:0] dbg_data
`endif
);

   typedef enum logic [3:0] {
      I_HALT  = 4'h0,
      I_NOP   = 4'h1,
      I_RRMOV = 4'h2,
      I_IRMOV = 4'h3,
      I_RMMOV = 4'h4,
      I_MRMOV = 4'h5,
      I_OPQ   = 4'h6,
      I_JXX   = 4'h7,
      I_CALL  = 4'h8,
      I_RET   = 4'h9,
      I_PUSH  = 4'hA,
      I_POP   = 4'hB
   } icode_e;

   typedef struct packed {
      logic [3:0]  icode;
      logic [3:0]  ifun;
      logic [3:0]  stat;
      logic [3:0]  dst_e;
      logic [3:0]  dst_m;
      logic [3:0]  src_a;
      logic [3:0]  src_b;
      logic [63:0] val_c;
      logic [63:0] val_a;
      logic [63:0] val_b;
   } e_reg_t;

   localparam int NREGS = 15;

   localparam e_reg_t E_BUBBLE = '{
      icode: I_NOP, ifun: 4'h0, stat: STAT_AOK,
      dst_e: RNONE, dst_m: RNONE, src_a: RNONE, src_b: RNONE,
      val_c: 64'd0, val_a: 64'd0, val_b: 64'd0
   };

   logic [63:0] regs [NREGS];
   logic [3:0]  d_dstE, d_dstM;
   logic [63:0] rf_a, rf_b;
   logic [63:0] d_valA, d_valB;
   logic        we_e, we_m;
   e_reg_t      e_q, e_d;

   // ------------------------------------------------------------------
   // Register identifier selection
   // ------------------------------------------------------------------
   always_comb begin
      d_srcA = RNONE;
      d_srcB = RNONE;
      d_dstE = RNONE;
      d_dstM = RNONE;
      case (D_icode)
         I_RRMOV: begin d_srcA = D_rA;                        d_dstE = D_rB;   end
         I_IRMOV: begin                                        d_dstE = D_rB;   end
         I_RMMOV: begin d_srcA = D_rA;   d_srcB = D_rB;                         end
         I_MRMOV: begin                  d_srcB = D_rB;        d_dstM = D_rA;   end
         I_OPQ:   begin d_srcA = D_rA;   d_srcB = D_rB;        d_dstE = D_rB;   end
         I_CALL:  begin                  d_srcB = RSP_ID;      d_dstE = RSP_ID; end
         I_RET:   begin d_srcA = RSP_ID; d_srcB = RSP_ID;      d_dstE = RSP_ID; end
         I_PUSH:  begin d_srcA = D_rA;   d_srcB = RSP_ID;      d_dstE = RSP_ID; end
         I_POP:   begin d_srcA = RSP_ID; d_srcB = RSP_ID;      d_dstE = RSP_ID;
                        d_dstM = D_rA;                                          end
         default: ;
      endcase
   end

   // ------------------------------------------------------------------
   // Register file: asynchronous read (pre-write value), synchronous write
   // ------------------------------------------------------------------
   always_comb begin
      rf_a = '0;
      rf_b = '0;
      for (int i = 0; i < NREGS; i++) begin
         if (d_srcA == 4'(i)) rf_a = regs[i];
         if (d_srcB == 4'(i)) rf_b = regs[i];
      end
   end

   assign we_e = (W_icode != I_HALT) && (W_dstE != RNONE);
   assign we_m = (W_icode != I_HALT) && (W_dstM != RNONE);

   // NOTE: the register file is architecturally zeroed on reset, so it is
   // built from flops with an async clear rather than an inferred RAM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            // The memory result takes precedence so popq %rsp loads the popped value.
            if (we_m && W_dstM == 4'(i))      regs[i] <= W_valM;
            else if (we_e && W_dstE == 4'(i)) regs[i] <= W_valE;
         end
      end
   end

   // ------------------------------------------------------------------
   // Forwarding: youngest producer wins; RNONE never matches a source
   // ------------------------------------------------------------------
   always_comb begin
      d_valA = '0;
      if (D_icode == I_JXX || D_icode == I_CALL) d_valA = D_valP;
      else if (d_srcA == RNONE)                  d_valA = '0;
      else if (d_srcA == e_dstE)                 d_valA = e_valE;
      else if (d_srcA == M_dstM)                 d_valA = m_valM;
      else if (d_srcA == M_dstE)                 d_valA = M_valE;
      else if (d_srcA == W_dstM)                 d_valA = W_valM;
      else if (d_srcA == W_dstE)                 d_valA = W_valE;
      else                                       d_valA = rf_a;
   end

   always_comb begin
      d_valB = '0;
      if (d_srcB == RNONE)       d_valB = '0;
      else if (d_srcB == e_dstE) d_valB = e_valE;
      else if (d_srcB == M_dstM) d_valB = m_valM;
      else if (d_srcB == M_dstE) d_valB = M_valE;
      else if (d_srcB == W_dstM) d_valB = W_valM;
      else if (d_srcB == W_dstE) d_valB = W_valE;
      else                       d_valB = rf_b;
   end

   // ------------------------------------------------------------------
   // E pipeline register
   // ------------------------------------------------------------------
   always_comb begin
      e_d = E_BUBBLE;
      if (!E_bubble) begin
         e_d.icode = D_icode;
         e_d.ifun  = D_ifun;
         e_d.stat  = D_stat;
         e_d.dst_e = d_dstE;
         e_d.dst_m = d_dstM;
         e_d.src_a = d_srcA;
         e_d.src_b = d_srcB;
         e_d.val_c = D_valC;
         e_d.val_a = d_valA;
         e_d.val_b = d_valB;
      end
   end

   // NOTE: state registers use non-blocking assignment so every flop samples
   // its inputs from before the edge, independent of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) e_q <= E_BUBBLE;
      else        e_q <= e_d;
   end

   assign E_icode = e_q.icode;
   assign E_ifun  = e_q.ifun;
   assign E_stat  = e_q.stat;
   assign E_dstE  = e_q.dst_e;
   assign E_dstM  = e_q.dst_m;
   assign E_srcA  = e_q.src_a;
   assign E_srcB  = e_q.src_b;
   assign E_valC  = e_q.val_c;
   assign E_valA  = e_q.val_a;
   assign E_valB  = e_q.val_b;

`ifdef DEC_REG_DEBUG_EN
   always_comb begin
      dbg_data = '0;
      for (int i = 0; i < NREGS; i++)
         if (dbg_sel == 4'(i)) dbg_data = regs[i];
   end
`endif

endmodule

// File: tb/tb_decode_writeback.sv
// Self-checking bench for decode_writeback: directed scenarios plus randomized
// traffic compared against an instruction-level reference model.
module tb_decode_writeback;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  D_icode, D_ifun, D_rA, D_rB, D_stat;
   logic [63:0] D_valC, D_valP;
   logic [3:0]  e_dstE;
   logic [63:0] e_valE;
   logic [3:0]  M_dstE, M_dstM;
   logic [63:0] M_valE, m_valM;
   logic [3:0]  W_icode, W_dstE, W_dstM;
   logic [63:0] W_valE, W_valM;
   logic        E_bubble;
   logic [3:0]  d_srcA, d_srcB;
   logic [3:0]  E_icode, E_ifun, E_stat, E_dstE, E_dstM, E_srcA, E_srcB;
   logic [63:0] E_valC, E_valA, E_valB;

   int checks   = 0;
   int failures = 0;

   logic [63:0] mreg [15];

   decode_writeback dut (
      .clk(clk), .rst_n(rst_n),
      .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB), .D_stat(D_stat),
      .D_valC(D_valC), .D_valP(D_valP),
      .e_dstE(e_dstE), .e_valE(e_valE),
      .M_dstE(M_dstE), .M_dstM(M_dstM), .M_valE(M_valE), .m_valM(m_valM),
      .W_icode(W_icode), .W_dstE(W_dstE), .W_dstM(W_dstM), .W_valE(W_valE), .W_valM(W_valM),
      .E_bubble(E_bubble),
      .d_srcA(d_srcA), .d_srcB(d_srcB),
      .E_icode(E_icode), .E_ifun(E_ifun), .E_stat(E_stat), .E_dstE(E_dstE), .E_dstM(E_dstM),
      .E_srcA(E_srcA), .E_srcB(E_srcB),
      .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [3:0] m_srcA(input logic [3:0] ic, input logic [3:0] ra);
      if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
      if (ic inside {4'h9, 4'hB}) return 4'h4;
      return 4'hF;
   endfunction

   function automatic logic [3:0] m_srcB(input logic [3:0] ic, input logic [3:0] rb);
      if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
      if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
      return 4'hF;
   endfunction

   function automatic logic [3:0] m_dstE(input logic [3:0] ic, input logic [3:0] rb);
      if (ic inside {4'h2, 4'h3, 4'h6}) return rb;
      if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
      return 4'hF;
   endfunction

   function automatic logic [3:0] m_dstM(input logic [3:0] ic, input logic [3:0] ra);
      if (ic inside {4'h5, 4'hB}) return ra;
      return 4'hF;
   endfunction

   function automatic logic [63:0] m_operand(input logic [3:0] src);
      if (src == 4'hF)    return 64'd0;
      if (src == e_dstE)  return e_valE;
      if (src == M_dstM)  return m_valM;
      if (src == M_dstE)  return M_valE;
      if (src == W_dstM)  return W_valM;
      if (src == W_dstE)  return W_valE;
      return mreg[src];
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic idle_inputs();
      D_icode = 4'h1; D_ifun = 4'h0; D_rA = 4'hF; D_rB = 4'hF; D_stat = 4'h1;
      D_valC = 64'd0; D_valP = 64'd0;
      e_dstE = 4'hF; e_valE = 64'd0;
      M_dstE = 4'hF; M_dstM = 4'hF; M_valE = 64'd0; m_valM = 64'd0;
      W_icode = 4'h1; W_dstE = 4'hF; W_dstM = 4'hF; W_valE = 64'd0; W_valM = 64'd0;
      E_bubble = 1'b0;
   endtask

   task automatic set_d(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb);
      D_icode = ic; D_rA = ra; D_rB = rb;
   endtask

   // Called just after a posedge with inputs already driven: checks the
   // combinational IDs, clocks one edge, then checks E and updates the model.
   task automatic step(input string tag);
      logic [3:0]  x_icode, x_ifun, x_stat, x_dstE, x_dstM, x_srcA, x_srcB;
      logic [63:0] x_valC, x_valA, x_valB;
      #1;
      check({tag, ".d_srcA"}, 64'(d_srcA), 64'(m_srcA(D_icode, D_rA)));
      check({tag, ".d_srcB"}, 64'(d_srcB), 64'(m_srcB(D_icode, D_rB)));
      if (E_bubble) begin
         x_icode = 4'h1; x_ifun = 4'h0; x_stat = 4'h1;
         x_dstE = 4'hF; x_dstM = 4'hF; x_srcA = 4'hF; x_srcB = 4'hF;
         x_valC = 64'd0; x_valA = 64'd0; x_valB = 64'd0;
      end else begin
         x_icode = D_icode; x_ifun = D_ifun; x_stat = D_stat;
         x_dstE = m_dstE(D_icode, D_rB); x_dstM = m_dstM(D_icode, D_rA);
         x_srcA = m_srcA(D_icode, D_rA); x_srcB = m_srcB(D_icode, D_rB);
         x_valC = D_valC;
         x_valA = (D_icode inside {4'h7, 4'h8}) ? D_valP : m_operand(x_srcA);
         x_valB = m_operand(x_srcB);
      end
      @(posedge clk);
      if (W_icode != 4'h0) begin
         if (W_dstE != 4'hF) mreg[W_dstE] = W_valE;
         if (W_dstM != 4'hF) mreg[W_dstM] = W_valM;
      end
      #1;
      check({tag, ".E_icode"}, 64'(E_icode), 64'(x_icode));
      check({tag, ".E_ifun"},  64'(E_ifun),  64'(x_ifun));
      check({tag, ".E_stat"},  64'(E_stat),  64'(x_stat));
      check({tag, ".E_dstE"},  64'(E_dstE),  64'(x_dstE));
      check({tag, ".E_dstM"},  64'(E_dstM),  64'(x_dstM));
      check({tag, ".E_srcA"},  64'(E_srcA),  64'(x_srcA));
      check({tag, ".E_srcB"},  64'(E_srcB),  64'(x_srcB));
      check({tag, ".E_valC"},  E_valC, x_valC);
      check({tag, ".E_valA"},  E_valA, x_valA);
      check({tag, ".E_valB"},  E_valB, x_valB);
   endtask

   task automatic check_bubble_now(input string tag);
      check({tag, ".E_icode"}, 64'(E_icode), 64'h1);
      check({tag, ".E_stat"},  64'(E_stat),  64'h1);
      check({tag, ".E_dstE"},  64'(E_dstE),  64'hF);
      check({tag, ".E_srcA"},  64'(E_srcA),  64'hF);
      check({tag, ".E_valA"},  E_valA, 64'd0);
      check({tag, ".E_valB"},  E_valB, 64'd0);
   endtask

   // Reads every register through decode with forwarding disabled.
   task automatic read_all_regs(input string tag);
      for (int r = 0; r < 15; r++) begin
         idle_inputs();
         set_d(4'h6, 4'(r), 4'(r));
         step(tag);
      end
   endtask

   initial begin
      for (int i = 0; i < 15; i++) mreg[i] = 64'd0;
      idle_inputs();
      rst_n = 1'b0;
      #22;
      check_bubble_now("por");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Load a few registers, then confirm them through decode.
      for (int r = 0; r < 15; r++) begin
         idle_inputs();
         W_icode = 4'h3; W_dstE = 4'(r); W_valE = 64'h1000 + 64'(r);
         step("fill");
      end
      read_all_regs("fill_rd");

      // Write-back then read.
      idle_inputs();
      W_icode = 4'h6; W_dstE = 4'h3; W_valE = 64'd100;
      step("wb3");
      idle_inputs();
      set_d(4'h6, 4'h3, 4'h3);
      step("opq33");
      check("opq33.valA100", E_valA, 64'd100);
      check("opq33.valB100", E_valB, 64'd100);
      check("opq33.dstE3",   64'(E_dstE), 64'd3);

      // Forward priority: execute beats memory.
      idle_inputs();
      set_d(4'h2, 4'h2, 4'h0);
      e_dstE = 4'h2; e_valE = 64'd7; M_dstE = 4'h2; M_valE = 64'd9;
      step("fwd_e");
      check("fwd_e.valA7", E_valA, 64'd7);
      e_dstE = 4'hF;
      step("fwd_m");
      check("fwd_m.valA9", E_valA, 64'd9);

      // call / jXX take valP.
      idle_inputs();
      D_icode = 4'h8; D_valP = 64'h40;
      step("call");
      check("call.valA",  E_valA, 64'h40);
      check("call.srcB4", 64'(E_srcB), 64'h4);
      check("call.dstE4", 64'(E_dstE), 64'h4);
      idle_inputs();
      D_icode = 4'h7; D_valP = 64'h1234_5678_9abc_def0; e_dstE = 4'hF;
      step("jxx");
      check("jxx.valA", E_valA, 64'h1234_5678_9abc_def0);

      // popq %rsp: memory value wins.
      idle_inputs();
      W_icode = 4'hB; W_dstE = 4'h4; W_valE = 64'd16; W_dstM = 4'h4; W_valM = 64'd55;
      step("popq_wr");
      idle_inputs();
      set_d(4'h6, 4'h4, 4'h4);
      step("popq_rd");
      check("popq_rd.reg4", E_valA, 64'd55);

      // Halt in write-back suppresses the write.
      idle_inputs();
      W_icode = 4'h0; W_dstE = 4'h5; W_valE = 64'hDEAD;
      step("halt_wr");
      idle_inputs();
      set_d(4'h6, 4'h5, 4'h5);
      step("halt_rd");
      check("halt_rd.reg5", E_valA, 64'h1005);

      // Bubble, then the same irmov passes.
      idle_inputs();
      set_d(4'h3, 4'hF, 4'h6);
      D_valC = 64'h77; E_bubble = 1'b1;
      step("bubble");
      check("bubble.icode1", 64'(E_icode), 64'h1);
      check("bubble.dstEF",  64'(E_dstE),  64'hF);
      E_bubble = 1'b0;
      step("irmov");
      check("irmov.icode3", 64'(E_icode), 64'h3);
      check("irmov.valC",   E_valC, 64'h77);

      // Randomized traffic.
      for (int n = 0; n < 400; n++) begin
         D_icode  = 4'($urandom_range(0, 15));
         D_ifun   = 4'($urandom);
         D_rA     = 4'($urandom);
         D_rB     = 4'($urandom);
         D_stat   = 4'($urandom);
         D_valC   = {$urandom, $urandom};
         D_valP   = {$urandom, $urandom};
         e_dstE   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
         e_valE   = {$urandom, $urandom};
         M_dstE   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
         M_dstM   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
         M_valE   = {$urandom, $urandom};
         m_valM   = {$urandom, $urandom};
         W_icode  = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 11));
         W_dstE   = ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'hF;
         W_dstM   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
         W_valE   = {$urandom, $urandom};
         W_valM   = {$urandom, $urandom};
         E_bubble = ($urandom_range(0, 5) == 0);
         step("rnd");
      end
      read_all_regs("rnd_rd");

      // Asynchronous reset mid-cycle after loading a live instruction.
      idle_inputs();
      set_d(4'h6, 4'h1, 4'h2);
      D_valC = 64'h5;
      step("pre_rst");
      #2;
      rst_n = 1'b0;
      #1;
      check_bubble_now("async_rst");
      for (int i = 0; i < 15; i++) mreg[i] = 64'd0;
      idle_inputs();
      W_icode = 4'h6; W_dstE = 4'h7; W_valE = 64'hBAD;
      @(posedge clk);
      #1;
      check_bubble_now("rst_hold");
      @(negedge clk);
      idle_inputs();
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      read_all_regs("post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/decode_writeback.md
Name: decode_writeback

Overview:
- Decode/write-back stage of the 5-stage Y86-64 pipeline; consumes the D register fields produced by fetch.
- Holds the 15x64 register file; selects srcA/srcB/dstE/dstM; forwards from E/M/W; writes W results.
- Registers everything into the E pipeline register, with bubble control from the hazard unit.

Parameters:
- RSP_ID, 4'h4, stack pointer register number.
- RNONE, 4'hF, "no register" encoding.
- STAT_AOK, 4'h1, status value inserted on bubble/reset.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- D_icode, D_ifun, D_rA, D_rB, D_stat  in  4 each  decode register fields from fetch.
- D_valC, D_valP  in  64 each  constant / next PC from fetch.
- e_dstE  in  4;  e_valE  in  64  execute-stage result.
- M_dstE, M_dstM  in  4 each;  M_valE, m_valM  in  64 each  memory-stage forward sources.
- W_icode, W_dstE, W_dstM  in  4 each;  W_valE, W_valM  in  64 each  write-back stage.
- E_bubble  in  1  load nop into E this cycle.
- d_srcA, d_srcB  out  4 each  combinational source IDs to the hazard unit.
- E_icode, E_ifun, E_stat, E_dstE, E_dstM, E_srcA, E_srcB  out  4 each  E register.
- E_valC, E_valA, E_valB  out  64 each  E register.

Behaviour:
- icodes: 0 halt, 1 nop, 2 rrmov/cmov, 3 irmov, 4 rmmov, 5 mrmov, 6 OPq, 7 jXX, 8 call, 9 ret, A push, B pop.
- srcA: rA for {2,4,6,A}; RSP_ID for {9,B}; else RNONE.
- srcB: rB for {4,5,6}; RSP_ID for {8,9,A,B}; else RNONE.
- dstE: rB for {2,3,6}; RSP_ID for {8,9,A,B}; else RNONE. dstM: rA for {5,B}; else RNONE.
- valA, first match wins: D_icode in {7,8} -> D_valP; srcA==e_dstE -> e_valE; ==M_dstM -> m_valM; ==M_dstE -> M_valE; ==W_dstM -> W_valM; ==W_dstE -> W_valE; else regfile[srcA].
- valB: same chain without the valP term.
- srcX==RNONE never matches any forward source and yields 0.
- Register file write at posedge clk: W_dstE!=RNONE -> reg[W_dstE]<=W_valE; W_dstM!=RNONE -> reg[W_dstM]<=W_valM.
- If W_dstE==W_dstM, W_valM wins (popq %rsp).
- No write when W_icode==0 (halt) or the destination is RNONE.
- E register latency 1 cycle. At posedge:
  - E_bubble=1: icode=1, ifun=0, stat=STAT_AOK, all IDs=RNONE, vals=0.
  - Else: load the decoded values; E_stat=D_stat, E_valC=D_valC.
- Reset (rst_n=0, asynchronous, effective immediately, including mid-instruction): all 15 registers = 0; E register = bubble value.
- Normal operation resumes on the first posedge after rst_n rises.
- The stage has no stall input; the hazard unit asserts E_bubble on load-use or mispredict.

Optional Feature:
- Macro DEC_REG_DEBUG_EN.
- When defined: extra ports dbg_sel (in, 4) and dbg_data (out, 64).
  - dbg_data = regfile[dbg_sel] combinationally, pre-write value (no W bypass).
  - dbg_sel==RNONE gives 0.
- When undefined: ports absent; behaviour otherwise identical.

Test Plan:
- Reset: rst_n=0 mid-cycle -> E_icode=1, E_dstE=F, E_valA=0 immediately; all registers read 0 afterwards.
- Writeback then read: W_dstE=3, W_valE=64'd100, then D=OPq rA=3 rB=3 -> E_valA=E_valB=100, E_dstE=3.
- Forward priority: e_dstE=2/e_valE=7 and M_dstE=2/M_valE=9 at the same time, D=rrmov rA=2 -> E_valA=7. Remove e_dstE -> E_valA=9.
- call/jXX: D_icode=8, D_valP=64'h40 -> E_valA=64'h40, E_srcB=4, E_dstE=4. D_icode=7 -> E_valA=D_valP.
- popq %rsp write: W_dstE=4/W_valE=16 and W_dstM=4/W_valM=55 -> reg[4]=55.
- Bubble: E_bubble=1 with D=irmov -> E_icode=1, E_dstE=F. Next cycle E_bubble=0 -> irmov values appear in E.
